// File: rtl/tenyr_bus_pkg.sv
// Shared types and constants for the tenyr data-bus fabric and its address decoder.
package tenyr_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic RW_READ  = 1'b0;
   localparam logic RW_WRITE = 1'b1;

   localparam logic [31:0] DEFAULT_RDATA = 32'hffff_ffff;

   // Width of a slave index; a single slave still needs one bit.
   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tenyr_bus_if.sv
// Core-side and device-side signals of the tenyr data bus.
// Handshake: the core holds m_strobe with stable m_rw/m_addr/m_wdata until a one-cycle m_ready;
// m_err and m_rdata are valid while m_ready is high. Each selected slave gets a one-cycle s_strobe
// and answers with s_ack (same cycle or later); s_ack from unselected slaves is ignored.
interface tenyr_bus_if #(
   parameter int NSLAVES = 4,
   parameter int AW      = 32,
   parameter int DW      = 32
) ();
   logic                  m_strobe;
   logic                  m_rw;
   logic [AW-1:0]         m_addr;
   logic [DW-1:0]         m_wdata;
   logic [DW-1:0]         m_rdata;
   logic                  m_ready;
   logic                  m_err;
   logic [NSLAVES-1:0]    s_strobe;
   logic                  s_rw;
   logic [AW-1:0]         s_addr;
   logic [DW-1:0]         s_wdata;
   logic [NSLAVES*DW-1:0] s_rdata;
   logic [NSLAVES-1:0]    s_ack;

   // Fabric view: serves the core, drives the devices.
   modport slave (
      input  m_strobe, m_rw, m_addr, m_wdata, s_rdata, s_ack,
      output m_rdata, m_ready, m_err, s_strobe, s_rw, s_addr, s_wdata
   );

   // Environment view: the core plus all memory-mapped devices.
   modport master (
      output m_strobe, m_rw, m_addr, m_wdata, s_rdata, s_ack,
      input  m_rdata, m_ready, m_err, s_strobe, s_rw, s_addr, s_wdata
   );
endinterface

// File: rtl/tenyr_bus_decode.sv
// Combinational base/mask address decoder; on overlapping windows the lowest slave index wins.
module tenyr_bus_decode #(
   parameter int                    NSLAVES = 4,
   parameter int                    AW      = 32,
   parameter int                    SW      = 2,
   parameter logic [NSLAVES*AW-1:0] BASES   = '0,
   parameter logic [NSLAVES*AW-1:0] MASKS   = '0
) (
   input  logic [AW-1:0] addr_i,
   output logic          hit_o,
   output logic [SW-1:0] sel_o
);

   // Scan from the top down so the last (lowest) match sticks.
   always_comb begin
      hit_o = 1'b0;
      sel_o = '0;
      for (int i = NSLAVES - 1; i >= 0; i--) begin
         if ((addr_i & MASKS[i*AW +: AW]) == BASES[i*AW +: AW]) begin
            hit_o = 1'b1;
            sel_o = SW'(i);
         end
      end
   end

endmodule

// File: rtl/tenyr_bus_fabric.sv
// Single-master data-bus interconnect: table-driven decode, ready handshake, timeout watchdog, error response.
// Optional error log enabled by defining TENYR_BUS_ERRLOG_EN.
module tenyr_bus_fabric
   import tenyr_bus_pkg::*;
#(
   parameter int                    NSLAVES       = 4,
   parameter int                    AW            = 32,
   parameter int                    DW            = 32,
   parameter logic [NSLAVES*AW-1:0] BASES         = {32'h0000_0300, 32'h0000_0200,
                                                     32'h0000_0100, 32'h0000_0000},
   parameter logic [NSLAVES*AW-1:0] MASKS         = {4{32'hffff_ff00}},
   parameter int                    TIMEOUT       = 15,
   parameter logic [DW-1:0]         DEFAULT_RDATA = tenyr_bus_pkg::DEFAULT_RDATA
) (
   input  logic              clk,
   input  logic              reset,
   tenyr_bus_if.slave        bus,
   output logic [7:0]        err_count,
   output logic [AW-1:0]     err_addr,
   output state_t            dbg_state_o
);

   localparam int SW = sel_width(NSLAVES);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_t             state_q, state_d;
   logic [SW-1:0]      sel_q, sel_d;
   logic [TW-1:0]      timer_q, timer_d;
   logic [DW-1:0]      m_rdata_q, m_rdata_d;
   logic               m_ready_q, m_ready_d;
   logic               m_err_q, m_err_d;
   logic [NSLAVES-1:0] s_strobe_q, s_strobe_d;
   logic               s_rw_q, s_rw_d;
   logic [AW-1:0]      s_addr_q, s_addr_d;
   logic [DW-1:0]      s_wdata_q, s_wdata_d;

   logic               dec_hit;
   logic [SW-1:0]      dec_sel;
   logic [NSLAVES-1:0] dec_onehot;
   logic               ack_sel;
   logic [DW-1:0]      rdata_sel;
   logic               err_set;
   logic [AW-1:0]      err_set_addr;

   tenyr_bus_decode #(
      .NSLAVES (NSLAVES),
      .AW      (AW),
      .SW      (SW),
      .BASES   (BASES),
      .MASKS   (MASKS)
   ) u_decode (
      .addr_i (bus.m_addr),
      .hit_o  (dec_hit),
      .sel_o  (dec_sel)
   );

   always_comb begin
      for (int i = 0; i < NSLAVES; i++) begin
         dec_onehot[i] = (dec_sel == SW'(i));
      end
   end

   assign ack_sel   = bus.s_ack[sel_q];
   assign rdata_sel = bus.s_rdata[sel_q*DW +: DW];

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         sel_q      <= '0;
         timer_q    <= '0;
         m_rdata_q  <= '0;
         m_ready_q  <= 1'b0;
         m_err_q    <= 1'b0;
         s_strobe_q <= '0;
         s_rw_q     <= 1'b0;
         s_addr_q   <= '0;
         s_wdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         timer_q    <= timer_d;
         m_rdata_q  <= m_rdata_d;
         m_ready_q  <= m_ready_d;
         m_err_q    <= m_err_d;
         s_strobe_q <= s_strobe_d;
         s_rw_q     <= s_rw_d;
         s_addr_q   <= s_addr_d;
         s_wdata_q  <= s_wdata_d;
      end
   end

   // m_ready and s_strobe are registered pulses: each is raised only on entry to RESP / ACTIVE.
   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      timer_d      = timer_q;
      m_rdata_d    = m_rdata_q;
      m_ready_d    = 1'b0;
      m_err_d      = m_err_q;
      s_strobe_d   = '0;
      s_rw_d       = s_rw_q;
      s_addr_d     = s_addr_q;
      s_wdata_d    = s_wdata_q;
      err_set      = 1'b0;
      err_set_addr = s_addr_q;

      case (state_q)
         ST_IDLE: begin
            if (bus.m_strobe) begin
               s_rw_d    = bus.m_rw;
               s_addr_d  = bus.m_addr;
               s_wdata_d = bus.m_wdata;
               sel_d     = dec_sel;
               timer_d   = '0;
               if (dec_hit) begin
                  state_d    = ST_ACTIVE;
                  s_strobe_d = dec_onehot;
               end else begin
                  state_d      = ST_RESP;
                  m_ready_d    = 1'b1;
                  m_err_d      = 1'b1;
                  m_rdata_d    = DEFAULT_RDATA;
                  err_set      = 1'b1;
                  err_set_addr = bus.m_addr;
               end
            end
         end

         ST_ACTIVE: begin
            if (ack_sel) begin
               state_d   = ST_RESP;
               m_ready_d = 1'b1;
               m_err_d   = 1'b0;
               timer_d   = '0;
               if (s_rw_q == RW_READ) begin
                  m_rdata_d = rdata_sel;
               end
            end else if (timer_q == TW'(TIMEOUT - 1)) begin
               state_d   = ST_RESP;
               m_ready_d = 1'b1;
               m_err_d   = 1'b1;
               m_rdata_d = DEFAULT_RDATA;
               timer_d   = '0;
               err_set   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end

         ST_RESP: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.m_rdata  = m_rdata_q;
   assign bus.m_ready  = m_ready_q;
   assign bus.m_err    = m_err_q;
   assign bus.s_strobe = s_strobe_q;
   assign bus.s_rw     = s_rw_q;
   assign bus.s_addr   = s_addr_q;
   assign bus.s_wdata  = s_wdata_q;
   assign dbg_state_o  = state_q;

`ifdef TENYR_BUS_ERRLOG_EN
   logic [7:0]    err_count_q, err_count_d;
   logic [AW-1:0] err_addr_q, err_addr_d;

   always_comb begin
      err_count_d = err_count_q;
      err_addr_d  = err_addr_q;
      if (err_set) begin
         err_addr_d = err_set_addr;
         if (err_count_q != 8'hff) begin
            err_count_d = err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_count_q <= '0;
         err_addr_q  <= '0;
      end else begin
         err_count_q <= err_count_d;
         err_addr_q  <= err_addr_d;
      end
   end

   assign err_count = err_count_q;
   assign err_addr  = err_addr_q;
`else
   logic unused_err_log;
   assign unused_err_log = ^{err_set, err_set_addr};
   assign err_count      = '0;
   assign err_addr       = '0;
`endif

endmodule
